network_sequencer: RTL and testbench
====================================

Name: network_sequencer

Overview:
Top-level controller for the CNN inference datapath (conv1 → maxpool/relu ×3 → fc_layer → argmax). Per inference it:
- pulses a soft reset to the network,
- optionally loads conv weights through the calc_weight port,
- buffers host pixels in a small FIFO and streams exactly HEIGHT*WIDTH pixels under valid/ready,
- waits for the class result with a timeout guard.

Parameters:
DATA_BITS, 8, pixel/weight width
HEIGHT, 28, image rows
WIDTH, 28, image columns
NUM_WEIGHTS, 49, weight writes per load phase (max 64)
FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
NET_RST_CYCLES, 2, soft-reset low cycles
TIMEOUT_CYCLES, 65535, max WAIT_RES cycles

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  begin inference (IDLE only)
load_weights  in  1  sampled with start; 1 = run LOAD_W phase
abort  in  1  sync abort to IDLE
w_valid  in  1  host weight valid
w_ready  out  1  host weight ready
w_addr  in  6  weight address
w_data  in  DATA_BITS  signed weight
pix_valid  in  1  host pixel valid
pix_ready  out  1  host pixel ready
pix_data  in  DATA_BITS  pixel
net_rst_n  out  1  network soft reset, active-low
net_weight_en  out  1  to calc_weight_en
net_weight_addr  out  6  to calc_weight_addr
net_weight_data  out  DATA_BITS  to calc_weight_in
net_data  out  DATA_BITS  to data_in
net_valid  out  1  to valid_in
net_ready  in  1  from ready
net_class  in  4  from class_out
net_done  in  1  from valid_out_network
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
class_out  out  4  captured class
timeout_err  out  1  sticky timeout flag
perf_cycles  out  32  start-to-done latency

Behaviour:
Clock and reset:
- Single clk domain. rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: net_rst_n=1, w_ready=0, pix_ready=0, net_valid=0, net_weight_en=0, net_weight_addr=0, net_weight_data=0, net_data=0, busy=0, done=0, class_out=0, timeout_err=0, perf_cycles=0. FIFO empty, all counters 0.

States:
- IDLE: on start=1, latch load_weights, clear timeout_err, clear pixel counters, go to NET_RST.
- NET_RST: net_rst_n=0 for NET_RST_CYCLES cycles. Then go to LOAD_W if latched load_weights=1, else STREAM.
- LOAD_W: w_ready=1.
  - A transfer occurs when w_valid && w_ready.
  - The cycle after each transfer: net_weight_en=1 with the transferred addr/data. Otherwise net_weight_en=0.
  - After the NUM_WEIGHTS-th transfer, drop w_ready and go to STREAM.
- STREAM:
  - net_valid = FIFO not empty. net_data = FIFO head (first-word fall-through).
  - A pixel is consumed when net_valid && net_ready.
  - After HEIGHT*WIDTH consumed pixels (784 at default), go to WAIT_RES.
- WAIT_RES:
  - On net_done: capture net_class into class_out and go to DONE.
  - Timeout counter reaching TIMEOUT_CYCLES with no net_done: set timeout_err, class_out=4'hF, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.

Pixel FIFO:
- pix_ready = FIFO not full AND state ∈ {NET_RST, LOAD_W, STREAM} AND accepted count < HEIGHT*WIDTH.
- Prefill during NET_RST/LOAD_W is allowed. Pixels beyond 784 are never accepted.
- Simultaneous push and pop when full: pop frees the slot next cycle. pix_ready is based on registered count, so no push is accepted in that cycle.
- Simultaneous push and pop when empty is allowed only via registered count; the popped word is never the same-cycle push.

Boundary rules:
- start while busy: ignored.
- net_done outside WAIT_RES: ignored.
- abort (any state except IDLE):
  - next cycle: state=IDLE, FIFO flushed, counters cleared, net_valid=0, w_ready=0, pix_ready=0;
  - net_rst_n pulses low NET_RST_CYCLES cycles;
  - no done pulse.
- abort and start in the same cycle: abort wins; start is ignored.
- rst_n asserted mid-inference: immediate return to reset values.
- Counters: pixel counters 10 bits, timeout counter 16 bits, perf counter 32 bits saturating.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: a 32-bit counter clears on accepted start, increments each busy cycle, and freezes into perf_cycles on DONE entry. perf_cycles holds until the next start.
- Undefined: counter logic is absent and perf_cycles is tied to 0.

Test Plan:
- start with load_weights=1, 49 weights addr 0..48 data = addr-24, then 784 pixels = index mod 256, net_ready always 1, net_done with net_class=7 forty cycles after the last pixel → exactly 49 net_weight_en pulses with matching addr/data, 784 net_valid handshakes in order, net_rst_n low 2 cycles, done 1 cycle, class_out=7.
- start with load_weights=0, net_ready toggling 1/0, host pix_valid random → no pixel lost, duplicated or reordered; net_valid never drops before 784; pix_ready=0 once FIFO holds 16 entries.
- Feed 800 pixels → only 784 accepted; pix_ready=0 afterwards; STREAM exits after 784.
- Withhold net_done, TIMEOUT_CYCLES=100 → timeout_err=1, class_out=4'hF, done pulse at WAIT_RES+100; the next start clears timeout_err.
- abort in mid-STREAM after 300 pixels → busy=0 next cycle, FIFO empty, net_rst_n low 2 cycles, no done. A following inference completes normally with class_out=3.
- SEQ_PERF_CNT_EN defined, fixed-latency run → perf_cycles equals the start-to-done cycle count measured by the bench. Macro undefined → perf_cycles=0.

Source files
------------

// File: rtl/network_sequencer.sv
// Inference sequencer: soft-resets the CNN, optionally loads weights, streams HEIGHT*WIDTH pixels
// through a small FWFT FIFO and collects the class result. Build option: SEQ_PERF_CNT_EN.
module network_sequencer #(
  parameter int DATA_BITS      = 8,
  parameter int HEIGHT         = 28,
  parameter int WIDTH          = 28,
  parameter int NUM_WEIGHTS    = 49,
  parameter int FIFO_DEPTH     = 16,
  parameter int NET_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 load_weights,
  input  logic                 abort,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [5:0]           w_addr,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [DATA_BITS-1:0] pix_data,
  output logic                 net_rst_n,
  output logic                 net_weight_en,
  output logic [5:0]           net_weight_addr,
  output logic [DATA_BITS-1:0] net_weight_data,
  output logic [DATA_BITS-1:0] net_data,
  output logic                 net_valid,
  input  logic                 net_ready,
  input  logic [3:0]           net_class,
  input  logic                 net_done,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           class_out,
  output logic                 timeout_err,
  output logic [31:0]          perf_cycles
);
  localparam int NPIX = HEIGHT * WIDTH;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RW   = $clog2(NET_RST_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_NET_RST, S_LOAD_W, S_STREAM, S_WAIT_RES, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 lw_q, lw_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d, arst_cnt_q, arst_cnt_d;
  logic [6:0]           wcnt_q, wcnt_d;
  logic [9:0]           acc_cnt_q, acc_cnt_d, con_cnt_q, con_cnt_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 w_ready_q, w_ready_d, pix_ready_q, pix_ready_d;
  logic                 net_rst_n_q, net_rst_n_d, net_valid_q, net_valid_d;
  logic                 net_weight_en_q, net_weight_en_d;
  logic [5:0]           net_weight_addr_q, net_weight_addr_d;
  logic [DATA_BITS-1:0] net_weight_data_q, net_weight_data_d, net_data_q, net_data_d;
  logic                 busy_q, busy_d, done_q, done_d, timeout_err_q, timeout_err_d;
  logic [3:0]           class_out_q, class_out_d;

  logic push, pop, w_xfer, start_acc, abort_acc;

  always_comb begin
    push      = pix_valid && pix_ready_q;
    pop       = net_valid_q && net_ready;
    w_xfer    = w_valid && w_ready_q;
    start_acc = (state_q == S_IDLE) && start && !abort;
    abort_acc = (state_q != S_IDLE) && abort;

    state_d           = state_q;
    lw_d              = lw_q;
    rst_cnt_d         = rst_cnt_q;
    arst_cnt_d        = (arst_cnt_q != '0) ? arst_cnt_q - 1'b1 : arst_cnt_q;
    wcnt_d            = wcnt_q;
    tmo_cnt_d         = tmo_cnt_q;
    wr_ptr_d          = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d          = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d             = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    acc_cnt_d         = acc_cnt_q + 10'(push);
    con_cnt_d         = con_cnt_q + 10'(pop);
    net_weight_en_d   = 1'b0;
    net_weight_addr_d = net_weight_addr_q;
    net_weight_data_d = net_weight_data_q;
    timeout_err_d     = timeout_err_q;
    class_out_d       = class_out_q;

    case (state_q)
      S_IDLE: if (start_acc) begin
        state_d       = S_NET_RST;
        lw_d          = load_weights;
        timeout_err_d = 1'b0;
        rst_cnt_d     = '0;
        arst_cnt_d    = '0;
        wcnt_d        = '0;
        tmo_cnt_d     = '0;
        acc_cnt_d     = '0;
        con_cnt_d     = '0;
        wr_ptr_d      = '0;
        rd_ptr_d      = '0;
        cnt_d         = '0;
      end
      S_NET_RST: begin
        if (rst_cnt_q == RW'(NET_RST_CYCLES - 1)) state_d = lw_q ? S_LOAD_W : S_STREAM;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_LOAD_W: if (w_xfer) begin
        net_weight_en_d   = 1'b1;
        net_weight_addr_d = w_addr;
        net_weight_data_d = w_data;
        wcnt_d            = wcnt_q + 1'b1;
        if (wcnt_q == 7'(NUM_WEIGHTS - 1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        tmo_cnt_d = '0;
        if (pop && con_cnt_q == 10'(NPIX - 1)) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (net_done) begin
          class_out_d = net_class;
          state_d     = S_DONE;
        end else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          class_out_d   = 4'hF;
          state_d       = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort still soft-resets the network, timed by a separate counter that runs in IDLE.
    if (abort_acc) begin
      state_d         = S_IDLE;
      arst_cnt_d      = RW'(NET_RST_CYCLES);
      rst_cnt_d       = '0;
      wcnt_d          = '0;
      tmo_cnt_d       = '0;
      acc_cnt_d       = '0;
      con_cnt_d       = '0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      cnt_d           = '0;
      net_weight_en_d = 1'b0;
    end

    // Outputs are derived from next-state values so they are registered yet cycle-accurate.
    w_ready_d   = (state_d == S_LOAD_W);
    pix_ready_d = (cnt_d < (AW+1)'(FIFO_DEPTH)) && (acc_cnt_d < 10'(NPIX)) &&
                  (state_d == S_NET_RST || state_d == S_LOAD_W || state_d == S_STREAM);
    net_valid_d = (state_d == S_STREAM) && (cnt_d != '0);
    // Head register: a push into an otherwise empty FIFO becomes the head directly.
    net_data_d  = (push && rd_ptr_d == wr_ptr_q) ? pix_data : mem_q[rd_ptr_d];
    net_rst_n_d = !((state_d == S_NET_RST) || (arst_cnt_d != '0));
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      lw_q              <= 1'b0;
      rst_cnt_q         <= '0;
      arst_cnt_q        <= '0;
      wcnt_q            <= '0;
      acc_cnt_q         <= '0;
      con_cnt_q         <= '0;
      tmo_cnt_q         <= '0;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      cnt_q             <= '0;
      w_ready_q         <= 1'b0;
      pix_ready_q       <= 1'b0;
      net_rst_n_q       <= 1'b1;
      net_valid_q       <= 1'b0;
      net_weight_en_q   <= 1'b0;
      net_weight_addr_q <= '0;
      net_weight_data_q <= '0;
      net_data_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      timeout_err_q     <= 1'b0;
      class_out_q       <= '0;
    end else begin
      state_q           <= state_d;
      lw_q              <= lw_d;
      rst_cnt_q         <= rst_cnt_d;
      arst_cnt_q        <= arst_cnt_d;
      wcnt_q            <= wcnt_d;
      acc_cnt_q         <= acc_cnt_d;
      con_cnt_q         <= con_cnt_d;
      tmo_cnt_q         <= tmo_cnt_d;
      rd_ptr_q          <= rd_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
      cnt_q             <= cnt_d;
      w_ready_q         <= w_ready_d;
      pix_ready_q       <= pix_ready_d;
      net_rst_n_q       <= net_rst_n_d;
      net_valid_q       <= net_valid_d;
      net_weight_en_q   <= net_weight_en_d;
      net_weight_addr_q <= net_weight_addr_d;
      net_weight_data_q <= net_weight_data_d;
      net_data_q        <= net_data_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      timeout_err_q     <= timeout_err_d;
      class_out_q       <= class_out_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d, perf_cycles_q, perf_cycles_d;

  always_comb begin
    perf_cnt_d    = perf_cnt_q;
    perf_cycles_d = perf_cycles_q;
    if (state_q != S_IDLE && perf_cnt_q != '1) perf_cnt_d = perf_cnt_q + 1'b1;
    if (start_acc) begin
      perf_cnt_d    = '0;
      perf_cycles_d = '0;
    end else if (state_d == S_DONE && state_q != S_DONE) begin
      perf_cycles_d = perf_cnt_d;
    end
    if (abort_acc) perf_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
`else
  assign perf_cycles = '0;
`endif

  assign w_ready         = w_ready_q;
  assign pix_ready       = pix_ready_q;
  assign net_rst_n       = net_rst_n_q;
  assign net_valid       = net_valid_q;
  assign net_weight_en   = net_weight_en_q;
  assign net_weight_addr = net_weight_addr_q;
  assign net_weight_data = net_weight_data_q;
  assign net_data        = net_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout_err     = timeout_err_q;
  assign class_out       = class_out_q;
endmodule

// File: tb/tb_network_sequencer.sv
// Randomized bench for network_sequencer: queue-based model of weight/pixel traffic,
// inference latency and timeout, with a negedge monitor collecting protocol violations.
module tb_network_sequencer;
  localparam int NPIX = 784, NW = 49, TMO = 100, FD = 16, BUDGET = 6000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, load_weights = 1'b0, abort = 1'b0;
  logic w_valid = 1'b0;
  logic [5:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic net_ready = 1'b1, net_done = 1'b0;
  logic [3:0] net_class = '0;
  logic w_ready, pix_ready, net_rst_n, net_weight_en, net_valid, busy, done, timeout_err;
  logic [5:0] net_weight_addr;
  logic [7:0] net_weight_data, net_data;
  logic [3:0] class_out;
  logic [31:0] perf_cycles;

  int n_tests = 0, n_fail = 0, cyc = 0;

  network_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_weights(load_weights), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .net_rst_n(net_rst_n), .net_weight_en(net_weight_en), .net_weight_addr(net_weight_addr),
    .net_weight_data(net_weight_data), .net_data(net_data), .net_valid(net_valid),
    .net_ready(net_ready), .net_class(net_class), .net_done(net_done), .busy(busy),
    .done(done), .class_out(class_out), .timeout_err(timeout_err), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state: written only here, read by the stimulus process.
  int nrst_lo = 0, done_n = 0, done_cyc = 0, last_pop_cyc = 0;
  int run_pop = 0, run_acc = 0, occ = 0, run_max = 0;
  int viol_wen = 0, viol_valid = 0, viol_full = 0;
  bit nrst_prev = 1'b1, seen_v = 1'b0, wx_prev = 1'b0;
  logic [5:0] wa_prev = '0;
  logic [7:0] wd_prev = '0;
  logic [13:0] wq[$];
  logic [7:0] pq[$];

  always @(negedge clk) begin
    if (!net_rst_n && nrst_prev) begin
      run_pop = 0; run_acc = 0; occ = 0; run_max = 0; seen_v = 1'b0;
    end
    nrst_prev = net_rst_n;
    if (!net_rst_n) nrst_lo++;
    if (done) begin done_n++; done_cyc = cyc; end
    if (net_weight_en !== wx_prev) viol_wen++;
    else if (net_weight_en && (net_weight_addr !== wa_prev || net_weight_data !== wd_prev)) viol_wen++;
    if (net_weight_en) wq.push_back({net_weight_addr, net_weight_data});
    wx_prev = w_valid && w_ready; wa_prev = w_addr; wd_prev = w_data;
    if (net_valid) seen_v = 1'b1;
    if (seen_v && run_pop < NPIX && net_valid !== (occ != 0)) viol_valid++;
    if (pix_ready && (occ >= FD || !busy || run_acc >= NPIX)) viol_full++;
    if (pix_valid && pix_ready) begin run_acc++; occ++; end
    if (net_valid && net_ready) begin pq.push_back(net_data); run_pop++; occ--; last_pop_cyc = cyc; end
    if (occ > run_max) run_max = occ;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One inference; abort_at >= 0 aborts after that many consumed pixels.
  task automatic run_inf(input bit lw, input bit tog, input bit wr, input int npix,
                         input bit give_done, input logic [3:0] cls, input int abort_at,
                         input bit stray);
    int wb, pb, nb, db, t0, nbad;
    bit stop;
    logic [7:0] gen[$];
    for (int i = 0; i < npix; i++) gen.push_back(tog ? 8'($urandom) : 8'(i));
    wb = wq.size(); pb = pq.size(); nb = nrst_lo; db = done_n;
    start = 1'b1; load_weights = lw; t0 = cyc;
    tick();
    start = 1'b0; load_weights = 1'($urandom);
    chk("busy_on_start", busy, 1);
    chk("tmo_err_cleared", timeout_err, 0);
    tick();
    stop = 1'b0;
    fork
      begin : wdrv
        int i = 0;
        bit hs;
        while (lw && i < NW && !stop) begin
          w_valid = wr ? ($urandom_range(3) != 0) : 1'b1;
          w_addr = 6'(i); w_data = 8'(i - 24);
          hs = w_valid && w_ready;
          tick();
          if (hs) i++;
        end
        w_valid = 1'b0;
      end
      begin : pdrv
        int i = 0;
        bit hs;
        while (i < npix && !stop) begin
          pix_valid = tog ? ($urandom_range(9) != 0) : 1'b1;
          pix_data = gen[i];
          hs = pix_valid && pix_ready;
          tick();
          if (hs) i++;
        end
        pix_valid = 1'b0;
      end
      begin : rdrv
        while (!stop) begin
          net_ready = tog ? ~net_ready : 1'b1;
          tick();
        end
        net_ready = 1'b1;
      end
      begin : ddrv
        bit strayed = 1'b0;
        while (!stop && run_pop < NPIX) begin
          if (stray && !strayed && run_pop >= 100) begin
            strayed = 1'b1;
            start = 1'b1; net_done = 1'b1; net_class = 4'h9;
            tick();
            start = 1'b0; net_done = 1'b0;
          end else tick();
        end
        if (!stop && give_done) begin
          repeat (40) tick();
          net_class = cls; net_done = 1'b1;
          tick();
          net_done = 1'b0;
        end
      end
      begin : adrv
        if (abort_at >= 0) begin
          while (!stop && run_pop < abort_at) tick();
          abort = 1'b1; start = 1'b1;
          tick();
          abort = 1'b0; start = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_pix_ready", pix_ready, 0);
          chk("abort_net_valid", net_valid, 0);
          chk("abort_w_ready", w_ready, 0);
          repeat (4) tick();
          stop = 1'b1;
        end
      end
      begin : watch
        int n = 0;
        while (!stop && done_n == db && n < BUDGET) begin tick(); n++; end
        if (!stop && done_n == db) chk("run_cycle_budget", n, 0);
        stop = 1'b1;
      end
    join
    repeat (2) tick();
    if (abort_at >= 0) begin
      chk("abort_nrst_cycles", nrst_lo - nb, 4);
      chk("abort_no_done", done_n - db, 0);
      return;
    end
    chk("done_pulses", done_n - db, 1);
    chk("nrst_low_cycles", nrst_lo - nb, 2);
    chk("pix_consumed", pq.size() - pb, NPIX);
    chk("pix_accepted", run_acc, NPIX);
    nbad = 0;
    for (int i = 0; i < NPIX && pb + i < pq.size(); i++) if (pq[pb + i] !== gen[i]) nbad++;
    chk("pix_order", nbad, 0);
    chk("w_writes", wq.size() - wb, lw ? NW : 0);
    nbad = 0;
    for (int i = 0; i < NW && lw && wb + i < wq.size(); i++)
      if (wq[wb + i] !== {6'(i), 8'(i - 24)}) nbad++;
    chk("w_content", nbad, 0);
    chk("class_out", class_out, give_done ? cls : 4'hF);
    chk("timeout_err", timeout_err, !give_done);
    if (!give_done) chk("timeout_latency", done_cyc - last_pop_cyc, TMO + 1);
    if (tog) chk("fifo_fill_max", run_max, FD);
`ifdef SEQ_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, done_cyc - (t0 + 1));
`else
    chk("perf_cycles", perf_cycles, 0);
`endif
    chk("busy_after", busy, 0);
    chk("pix_ready_after", pix_ready, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_net_rst_n", net_rst_n, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_net_valid", net_valid, 0);
    chk("rst_weight_en", net_weight_en, 0);
    chk("rst_weight_addr", net_weight_addr, 0);
    chk("rst_weight_data", net_weight_data, 0);
    chk("rst_net_data", net_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_class", class_out, 0);
    chk("rst_tmo_err", timeout_err, 0);
    chk("rst_perf", perf_cycles, 0);
    rst_n = 1'b1;
    tick();
    run_inf(1, 0, 0, NPIX, 1, 4'd7, -1, 0);
    run_inf(0, 1, 0, NPIX, 1, 4'd5, -1, 1);
    run_inf(1, 0, 1, 800,  1, 4'd2, -1, 0);
    run_inf(0, 0, 0, NPIX, 0, 4'd0, -1, 0);
    run_inf(0, 1, 0, NPIX, 1, 4'd0, 300, 0);
    run_inf(1, 0, 1, NPIX, 1, 4'd3, -1, 0);
    // Reset asserted mid-inference returns outputs to reset values at once.
    start = 1'b1; load_weights = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_net_rst_n", net_rst_n, 1);
    chk("midrst_pix_ready", pix_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("viol_weight_en", viol_wen, 0);
    chk("viol_net_valid", viol_valid, 0);
    chk("viol_pix_ready", viol_full, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
